// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial
//  Description : Digit-serial WIDTH-bit ALU. Processes SLICE bits per clock,
//                LSB first, behind valid/ready handshakes on both sides.
//                Op codes: 2 ADD, 3 SUB, 4 AND, 5 OR, 6 NOR, 7 XOR; codes
//                0 and 1 yield a zero result. Adds carry-out, signed
//                overflow and zero flags on top of the plain slice datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_NSLICE = WIDTH / SLICE;
    // One extra bit so the counter can reach N without wrapping.
    localparam int C_CNT_W  = $clog2(C_NSLICE) + 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_NSLICE - 1);

    localparam logic [2:0] C_OP_ADD = 3'd2;
    localparam logic [2:0] C_OP_SUB = 3'd3;
    localparam logic [2:0] C_OP_AND = 3'd4;
    localparam logic [2:0] C_OP_OR  = 3'd5;
    localparam logic [2:0] C_OP_NOR = 3'd6;
    localparam logic [2:0] C_OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_a;        // operand A, shifted right one slice per RUN cycle
    logic [WIDTH-1:0]     r_b;        // operand B, shifted right one slice per RUN cycle
    logic [2:0]           r_ctrl;     // captured op code
    logic [C_CNT_W-1:0]   r_cnt;      // slice index
    logic                 r_carry;    // carry between slices
    logic [WIDTH-1:0]     r_acc;      // partial result, filled from the top down

    logic [WIDTH-1:0]     r_out;
    logic                 r_cout;
    logic                 r_ovf;
    logic                 r_zero;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_arith;
    logic                 w_in_arith;
    logic [SLICE-1:0]     w_a_s;
    logic [SLICE-1:0]     w_b_raw;
    logic [SLICE-1:0]     w_b_s;
    logic [SLICE:0]       w_sum;
    logic [SLICE-1:0]     w_res_s;
    logic                 w_cin_msb;
    logic                 w_cout_s;
    logic                 w_ovf_s;
    logic [WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]     w_a_shift;
    logic [WIDTH-1:0]     w_b_shift;

    // ------------------------------------------------------------------------
    // Slice datapath
    // ------------------------------------------------------------------------
    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_last     = (r_cnt == C_LAST);
    assign w_arith    = (r_ctrl == C_OP_ADD) || (r_ctrl == C_OP_SUB);
    assign w_in_arith = (control == C_OP_ADD) || (control == C_OP_SUB);

    // The current slice is always the low SLICE bits of the shifting operands.
    assign w_a_s   = r_a[SLICE-1:0];
    assign w_b_raw = r_b[SLICE-1:0];
    // SUB inverts B; the +1 enters through the carry seeded at accept.
    assign w_b_s   = w_b_raw ^ {SLICE{r_ctrl[0]}};
    assign w_sum   = {1'b0, w_a_s} + {1'b0, w_b_s} + {{SLICE{1'b0}}, r_carry};

    // Carry into the slice MSB is recovered from the MSB sum bit, which avoids
    // splitting the adder when SLICE == 1.
    assign w_cin_msb = w_a_s[SLICE-1] ^ w_b_s[SLICE-1] ^ w_sum[SLICE-1];
    assign w_cout_s  = w_arith & w_sum[SLICE];
    assign w_ovf_s   = w_arith & (w_cin_msb ^ w_sum[SLICE]);

    // Per-slice result selection by op code.
    always_comb begin
        w_res_s = '0;
        case (r_ctrl)
            C_OP_ADD,
            C_OP_SUB: w_res_s = w_sum[SLICE-1:0];
            C_OP_AND: w_res_s = w_a_s & w_b_raw;
            C_OP_OR : w_res_s = w_a_s | w_b_raw;
            C_OP_NOR: w_res_s = ~(w_a_s | w_b_raw);
            C_OP_XOR: w_res_s = w_a_s ^ w_b_raw;
            default : w_res_s = '0;
        endcase
    end

    // Shift paths; a single-slice configuration has nothing left to shift.
    generate
        if (SLICE < WIDTH) begin : g_shift_part
            assign w_acc_next = {w_res_s, r_acc[WIDTH-1:SLICE]};
            assign w_a_shift  = {{SLICE{1'b0}}, r_a[WIDTH-1:SLICE]};
            assign w_b_shift  = {{SLICE{1'b0}}, r_b[WIDTH-1:SLICE]};
        end else begin : g_shift_full
            assign w_acc_next = w_res_s;
            assign w_a_shift  = '0;
            assign w_b_shift  = '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand capture, slice iteration and result/flag update
    // ------------------------------------------------------------------------
    // Captures on accept, advances one slice per RUN cycle, and publishes the
    // result only on the last slice so out/flags hold until the next completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_ctrl  <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            r_out   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_ctrl  <= control;
            r_cnt   <= '0;
            r_carry <= w_in_arith & control[0];
            r_acc   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= w_a_shift;
            r_b     <= w_b_shift;
            r_acc   <= w_acc_next;
            r_carry <= w_sum[SLICE];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_out  <= w_acc_next;
                r_cout <= w_cout_s;
                r_ovf  <= w_ovf_s;
                r_zero <= (w_acc_next == '0);
            end
        end
    end

    assign out      = r_out;
    assign carryout = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_serial
//  Description : Self-checking bench for alu_serial. Three instances cover
//                8/1, 8/2 and 32/32 slicing; results are compared against an
//                arithmetic reference model working on whole words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial;

    localparam int WID [3] = '{8, 8, 32};
    localparam int SLC [3] = '{1, 2, 32};

    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    logic              clock;
    logic              reset;
    logic [2:0]        in_valid;
    logic [2:0]        out_ready;
    logic [2:0][31:0]  a_in;
    logic [2:0][31:0]  b_in;
    logic [2:0][2:0]   ctl;
    wire  [2:0]        in_ready;
    wire  [2:0]        out_valid;
    wire  [2:0]        cout;
    wire  [2:0]        ovf;
    wire  [2:0]        zro;
    wire  [7:0]        out0;
    wire  [7:0]        out1;
    wire  [31:0]       out2;

    int errors;
    int checks;
    int cur_sel;
    int done_cnt [3];
    int pulses   [3];
    logic [2:0] prev_ov;

    alu_serial #(.WIDTH(8), .SLICE(1)) u_d0 (
        .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a_in[0][7:0]), .B(b_in[0][7:0]), .control(ctl[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(out0),
        .carryout(cout[0]), .overflow(ovf[0]), .zero(zro[0])
    );

    alu_serial #(.WIDTH(8), .SLICE(2)) u_d1 (
        .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a_in[1][7:0]), .B(b_in[1][7:0]), .control(ctl[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(out1),
        .carryout(cout[1]), .overflow(ovf[1]), .zero(zro[1])
    );

    alu_serial #(.WIDTH(32), .SLICE(32)) u_d2 (
        .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(a_in[2]), .B(b_in[2]), .control(ctl[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out(out2),
        .carryout(cout[2]), .overflow(ovf[2]), .zero(zro[2])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Counts rising edges of each out_valid to catch lost or duplicated pulses.
    initial begin
        prev_ov = '0;
        for (int i = 0; i < 3; i++) pulses[i] = 0;
        forever begin
            @(posedge clock);
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i] && !prev_ov[i]) pulses[i]++;
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] obs_out(input int s);
        case (s)
            0:       return {24'd0, out0};
            1:       return {24'd0, out1};
            default: return out2;
        endcase
    endfunction

    // Whole-word reference: unsigned sum for carry, signed range test for overflow.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] c, output logic [31:0] r,
                                  output logic co, output logic ov, output logic z);
        longint unsigned mask;
        longint unsigned full;
        longint sa, sb, sr, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        sa   = a[w-1] ? longint'(64'(a)) - longint'(64'd1 << w) : longint'(64'(a));
        sb   = b[w-1] ? longint'(64'(b)) - longint'(64'd1 << w) : longint'(64'(b));
        smax = longint'(64'd1 << (w - 1)) - 1;
        smin = -longint'(64'd1 << (w - 1));
        full = 0;
        co   = 1'b0;
        ov   = 1'b0;
        case (c)
            3'd2: begin
                full = 64'(a) + 64'(b);
                sr   = sa + sb;
                co   = full[w];
                ov   = (sr > smax) || (sr < smin);
            end
            3'd3: begin
                full = 64'(a) + ((~64'(b)) & mask) + 64'd1;
                sr   = sa - sb;
                co   = full[w];
                ov   = (sr > smax) || (sr < smin);
            end
            3'd4:    full = 64'(a & b);
            3'd5:    full = 64'(a | b);
            3'd6:    full = (~64'(a | b)) & mask;
            3'd7:    full = 64'(a ^ b);
            default: full = 0;
        endcase
        r = 32'(full & mask);
        z = (r == 32'd0);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s sel=%0d observed=%0h expected=%0h", tag, cur_sel, obs, exp);
        end
    endtask

    // Runs one operation on instance sel: accept, count latency, check result,
    // optionally stall the consumer for hold cycles, then complete the handshake.
    // noisy keeps in_valid high and scrambles the operand inputs during RUN.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c, input int hold, input bit noisy);
        int w, n, lat, waited;
        logic [31:0] m, er;
        logic eco, eov, ez;
        cur_sel = sel;
        w = WID[sel];
        n = w / SLC[sel];
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        model(w, a & m, b & m, c, er, eco, eov, ez);

        waited = 0;
        while (!in_ready[sel] && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("ready_before_accept", 64'(in_ready[sel]), 64'd1);

        a_in[sel]     = a;
        b_in[sel]     = b;
        ctl[sel]      = c;
        in_valid[sel] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid[sel] = noisy;
        lat = 0;
        while (!out_valid[sel] && lat < 100) begin
            if (noisy) begin
                a_in[sel] = $urandom;
                b_in[sel] = $urandom;
                ctl[sel]  = 3'($urandom);
            end
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        in_valid[sel] = 1'b0;

        check("latency",   64'(lat),           64'(n));
        check("out",       64'(obs_out(sel)),  64'(er));
        check("carryout",  64'(cout[sel]),     64'(eco));
        check("overflow",  64'(ovf[sel]),      64'(eov));
        check("zero",      64'(zro[sel]),      64'(ez));
        check("ready_in_done", 64'(in_ready[sel]), 64'd0);

        if (hold > 0) begin
            repeat (hold) @(negedge clock);
            check("hold_valid",    64'(out_valid[sel]), 64'd1);
            check("hold_ready",    64'(in_ready[sel]),  64'd0);
            check("hold_out",      64'(obs_out(sel)),   64'(er));
            check("hold_flags",    64'({cout[sel], ovf[sel], zro[sel]}), 64'({eco, eov, ez}));
        end

        out_ready[sel] = 1'b1;
        @(negedge clock);
        out_ready[sel] = 1'b0;
        check("valid_drop",  64'(out_valid[sel]), 64'd0);
        check("ready_back",  64'(in_ready[sel]),  64'd1);
        check("out_kept",    64'(obs_out(sel)),   64'(er));
        done_cnt[sel]++;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cur_sel   = 0;
        reset     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        a_in      = '0;
        b_in      = '0;
        ctl       = '0;
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;

        // Reset state, observed while reset is still asserted.
        repeat (2) @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            cur_sel = s;
            check("rst_in_ready",  64'(in_ready[s]),  64'd1);
            check("rst_out_valid", 64'(out_valid[s]), 64'd0);
            check("rst_out",       64'(obs_out(s)),   64'd0);
            check("rst_flags",     64'({cout[s], ovf[s], zro[s]}), 64'(3'b001));
        end
        reset = 1'b1;
        @(negedge clock);

        // Directed cases.
        run_op(0, 32'h0F, 32'h01, OP_ADD, 0, 1'b0);
        check("dir_add_0f_01", 64'(out0), 64'h10);
        run_op(1, 32'h05, 32'h05, OP_SUB, 0, 1'b0);
        check("dir_sub_zero", 64'({out1, zro[1], cout[1], ovf[1]}), 64'({8'h00, 3'b110}));
        run_op(1, 32'h7F, 32'h01, OP_ADD, 0, 1'b0);
        check("dir_add_ovf", 64'({out1, ovf[1]}), 64'({8'h80, 1'b1}));
        run_op(2, 32'h0, 32'h0, OP_NOR, 0, 1'b0);
        check("dir_nor", 64'(out2), 64'hFFFF_FFFF);
        run_op(2, 32'hA5A5_A5A5, 32'hFFFF_0000, OP_XOR, 0, 1'b0);
        check("dir_xor", 64'(out2), 64'h5A5A_A5A5);
        run_op(0, 32'h3C, 32'hC5, OP_ADD, 5, 1'b1);
        run_op(0, 32'hFF, 32'h12, 3'd0, 0, 1'b0);
        run_op(0, 32'hAA, 32'h55, 3'd1, 0, 1'b0);

        // Reset in the middle of RUN, between clock edges.
        cur_sel     = 0;
        a_in[0]     = 32'h12;
        b_in[0]     = 32'h34;
        ctl[0]      = OP_ADD;
        in_valid[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrun_in_ready",  64'(in_ready[0]),  64'd1);
        check("midrun_out_valid", 64'(out_valid[0]), 64'd0);
        check("midrun_out",       64'(out0),         64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_op(0, 32'hFF, 32'h01, OP_ADD, 0, 1'b0);
        check("post_reset_add", 64'({out0, cout[0], zro[0]}), 64'({8'h00, 2'b11}));

        // Back-to-back random operations, every op code, every instance.
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 8; c++) begin
                repeat (20) begin
                    run_op(s, $urandom, $urandom, 3'(c), int'($urandom_range(0, 2)), 1'b0);
                end
            end
        end

        repeat (3) @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            cur_sel = s;
            check("pulse_count", 64'(pulses[s]), 64'(done_cnt[s]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
